// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM encoding and the signed-add overflow helper shared by alu_seq and its bench
package alu_pkg;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRA = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;
  typedef enum logic {IDLE, MUL} state_t;
  function automatic logic ov_add(input logic a, input logic b, input logic s);
    return (a == b) && (s != a);
  endfunction
endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative signed shift-add multiplier on nIO+1-bit magnitudes, one step per cycle
module alu_mul_seq #(
  parameter int nIO = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [nIO-1:0]   a,
  input  logic [nIO-1:0]   b,
  output logic             busy,
  output logic             done,
  output logic [2*nIO-1:0] p,
  output logic             ov
);
  localparam int CW = $clog2(nIO + 1);
  localparam int PW = 2 * nIO;
  logic          busy_q, busy_d, neg_q, neg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] mcand_q, mcand_d, acc_q, acc_d;
  logic [nIO:0]  mplier_q, mplier_d, mag_a, mag_b;
  assign busy = busy_q;
  always_comb begin
    mag_a = a[nIO-1] ? -{a[nIO-1], a} : {a[nIO-1], a};
    mag_b = b[nIO-1] ? -{b[nIO-1], b} : {b[nIO-1], b};
    done = busy_q && cnt_q == CW'(nIO);
    busy_d = busy_q;
    neg_d = neg_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    if (start && !busy_q) begin
      busy_d = 1'b1;
      neg_d = a[nIO-1] ^ b[nIO-1];
      cnt_d = '0;
      acc_d = '0;
      mcand_d = PW'(mag_a);
      mplier_d = mag_b;
    end else if (done) begin
      busy_d = 1'b0;
    end else if (busy_q) begin
      acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d = cnt_q + 1'b1;
    end
    p = neg_q ? -acc_q : acc_q;
    ov = (p[PW-1:nIO-1] != '0) && (p[PW-1:nIO-1] != '1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      neg_q <= 1'b0;
      cnt_q <= '0;
      acc_q <= '0;
      mcand_q <= '0;
      mplier_q <= '0;
    end else begin
      busy_q <= busy_d;
      neg_q <= neg_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked registered ALU with multi-cycle multiply, optional saturation and sticky overflow
module alu_seq import alu_pkg::*; #(
  parameter int nIO    = 8,
  parameter bit SAT_EN = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [nIO-1:0] A,
  input  logic [nIO-1:0] B,
  input  logic [2:0]     OP,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [nIO-1:0] Z,
  output logic           OV,
  output logic           ov_sticky,
  input  logic           clr_sticky
);
  state_t           state_q, state_d;
  logic             out_valid_q, out_valid_d, ov_q, ov_d, sticky_q, sticky_d;
  logic [nIO-1:0]   z_q, z_d;
  logic             accept, load, mul_start, mul_busy, mul_done, mul_ov, mul_pos;
  logic [2*nIO-1:0] mul_p, shl_w;
  logic [nIO-1:0]   sum, dif, sra_r, res, raw, sat;
  logic             big, r_ov, r_pos, n_ov;
  assign in_ready = rst_n && state_q == IDLE && !mul_busy && (!out_valid_q || out_ready);
  assign accept = in_valid && in_ready;
  assign mul_start = accept && OP == OP_MUL;
  assign out_valid = out_valid_q;
  assign Z = z_q;
  assign OV = ov_q;
  assign ov_sticky = sticky_q;
  alu_mul_seq #(.nIO(nIO)) u_mul (
    .clk(clk),
    .rst_n(rst_n),
    .start(mul_start),
    .a(A),
    .b(B),
    .busy(mul_busy),
    .done(mul_done),
    .p(mul_p),
    .ov(mul_ov)
  );
  always_comb begin
    sum = A + B;
    dif = A - B;
    big = B >= nIO'(nIO);
    shl_w = {{nIO{1'b0}}, A} << B;
    sra_r = $signed(A) >>> B;
    res = '0;
    r_ov = 1'b0;
    r_pos = 1'b0;
    case (OP)
      OP_ADD: begin
        res = sum;
        r_ov = ov_add(A[nIO-1], B[nIO-1], sum[nIO-1]);
        r_pos = sum[nIO-1];
      end
      OP_SUB: begin
        res = dif;
        r_ov = ov_add(A[nIO-1], ~B[nIO-1], dif[nIO-1]);
        r_pos = dif[nIO-1];
      end
      OP_AND: res = A & B;
      OP_OR:  res = A | B;
      OP_XOR: res = A ^ B;
      OP_SLL: begin
        res = big ? '0 : shl_w[nIO-1:0];
        r_ov = A != '0 && (big || shl_w[2*nIO-1:nIO] != '0 || shl_w[nIO-1] != A[nIO-1]);
        r_pos = !A[nIO-1];
      end
      OP_SRA: res = sra_r;
      default: ;
    endcase
    mul_pos = !mul_p[2*nIO-1] && mul_p != '0;
    raw = mul_done ? mul_p[nIO-1:0] : res;
    n_ov = mul_done ? mul_ov : r_ov;
    sat = (mul_done ? mul_pos : r_pos) ? {1'b0, {(nIO-1){1'b1}}} : {1'b1, {(nIO-1){1'b0}}};
    load = mul_done || (accept && OP != OP_MUL);
    out_valid_d = load || (out_valid_q && !out_ready);
    z_d = load ? ((SAT_EN && n_ov) ? sat : raw) : z_q;
    ov_d = load ? n_ov : ov_q;
    sticky_d = (load && n_ov) || (sticky_q && !clr_sticky);
    state_d = mul_start ? MUL : mul_done ? IDLE : state_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_valid_q <= 1'b0;
      z_q <= '0;
      ov_q <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_valid_q <= out_valid_d;
      z_q <= z_d;
      ov_q <= ov_d;
      sticky_q <= sticky_d;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors against a wrapping and a saturating alu_seq sharing one stimulus
module tb_alu_seq;
  import alu_pkg::*;
  logic       clk, rst_n, in_valid, out_ready, clr_sticky;
  logic [7:0] A, B;
  logic [2:0] OP;
  logic       in_ready0, out_valid0, ov0, sticky0;
  logic       in_ready1, out_valid1, ov1, sticky1;
  logic [7:0] z0, z1;
  int checks = 0;
  int errors = 0;
  alu_seq #(.nIO(8), .SAT_EN(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .A(A), .B(B), .OP(OP), .out_valid(out_valid0), .out_ready(out_ready),
    .Z(z0), .OV(ov0), .ov_sticky(sticky0), .clr_sticky(clr_sticky)
  );
  alu_seq #(.nIO(8), .SAT_EN(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .A(A), .B(B), .OP(OP), .out_valid(out_valid1), .out_ready(out_ready),
    .Z(z1), .OV(ov1), .ov_sticky(sticky1), .clr_sticky(clr_sticky)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o);
    int n = 0;
    A = a;
    B = b;
    OP = o;
    in_valid = 1'b1;
    while (!in_ready0 && n < 20) begin
      tick();
      n++;
    end
    chk("accept", in_ready0, 1'b1);
    tick();
    in_valid = 1'b0;
  endtask
  task automatic mul_run(input logic [7:0] a, input logic [7:0] b);
    send(a, b, OP_MUL);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("mul_busy", {in_ready0, out_valid0}, 2'b00);
    end
    tick();
    chk("mul_valid", {out_valid0, out_valid1}, 2'b11);
  endtask
  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    clr_sticky = 1'b0;
    A = '0;
    B = '0;
    OP = OP_ADD;
    tick();
    tick();
    chk("rst_valid", out_valid0, 1'b0);
    chk("rst_z", z0, 8'h00);
    chk("rst_ov", ov0, 1'b0);
    chk("rst_sticky", sticky0, 1'b0);
    chk("rst_ready", in_ready0, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("idle_ready", in_ready0, 1'b1);
    send(8'd100, 8'd50, OP_ADD);
    chk("add_valid", out_valid0, 1'b1);
    chk("add_z", z0, 8'h96);
    chk("add_ov", ov0, 1'b1);
    chk("add_sticky", sticky0, 1'b1);
    chk("add_sat_z", z1, 8'h7F);
    chk("add_sat_ov", ov1, 1'b1);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    chk("clr_sticky", sticky0, 1'b0);
    send(8'd20, 8'hF9, OP_ADD);
    chk("add2_z", z0, 8'd13);
    chk("add2_ov", ov0, ov_add(1'b0, 1'b1, 1'b0));
    chk("add2_sticky", sticky0, 1'b0);
    send(8'h9C, 8'd50, OP_SUB);
    chk("sub_z", z0, 8'h6A);
    chk("sub_ov", ov0, 1'b1);
    chk("sub_sat_z", z1, 8'h80);
    send(8'hF0, 8'h3C, OP_AND);
    chk("and_z", {ov0, z0}, 9'h030);
    send(8'hF0, 8'h3C, OP_OR);
    chk("or_z", {ov0, z0}, 9'h0FC);
    send(8'hF0, 8'h3C, OP_XOR);
    chk("xor_z", {ov0, z0}, 9'h0CC);
    send(8'h40, 8'd1, OP_SLL);
    chk("sll_z", z0, 8'h80);
    chk("sll_ov", ov0, 1'b1);
    chk("sll_sat_z", z1, 8'h7F);
    send(8'h81, 8'd9, OP_SRA);
    chk("sra_z", z0, 8'hFF);
    chk("sra_ov", ov0, 1'b0);
    send(8'd5, 8'd8, OP_SLL);
    chk("sll_big_z", z0, 8'h00);
    chk("sll_big_ov", ov0, 1'b1);
    send(8'h00, 8'd3, OP_SLL);
    chk("sll_zero_ov", {ov0, z0}, 9'h000);
    mul_run(8'hFD, 8'd5);
    chk("mul_z", z0, 8'hF1);
    chk("mul_ov", ov0, 1'b0);
    chk("mul_sat_z", z1, 8'hF1);
    mul_run(8'd16, 8'd16);
    chk("mul_big_z", z0, 8'h00);
    chk("mul_big_ov", ov0, 1'b1);
    chk("mul_big_sat_z", z1, 8'h7F);
    mul_run(8'h80, 8'd1);
    chk("mul_min_z", z0, 8'h80);
    chk("mul_min_ov", ov0, 1'b0);
    tick();
    out_ready = 1'b0;
    send(8'd1, 8'd2, OP_ADD);
    chk("bp_first", z0, 8'd3);
    A = 8'd7;
    B = 8'd7;
    OP = OP_ADD;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold", {in_ready0, out_valid0, ov0, z0}, {1'b0, 1'b1, 1'b0, 8'd3});
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready0, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("bp_next", {out_valid0, z0}, {1'b1, 8'd14});
    clr_sticky = 1'b1;
    tick();
    chk("clr_again", sticky0, 1'b0);
    send(8'd100, 8'd50, OP_ADD);
    clr_sticky = 1'b0;
    chk("clr_vs_set", sticky0, 1'b1);
    tick();
    send(8'hFD, 8'd5, OP_MUL);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid0, 1'b0);
    chk("mid_rst_z", z0, 8'h00);
    chk("mid_rst_sticky", sticky0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    send(8'd1, 8'd1, OP_ADD);
    chk("post_rst_add", {out_valid0, z0}, {1'b1, 8'd2});
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("no_stale_mul", out_valid0, 1'b0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
